parallel_printer_out: RTL



---
 rtl/parallel_printer_out.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/parallel_printer_out.sv
// Centronics-style printer output engine: a byte FIFO feeding a strobe/busy
// handshake FSM that drives the parallel-port data and strobe pads.
module parallel_printer_out #(
  parameter int DEPTH_LOG2   = 4,
  parameter int SETUP_CYC    = 32,
  parameter int STROBE_CYC   = 32,
  parameter int HOLD_CYC     = 32,
  parameter int TIMEOUT_LOG2 = 25
) (
  input  logic                clk32,
  input  logic                por,
  input  logic                en,
  input  logic                wr,
  input  logic [7:0]          wdata,
  input  logic                busy_pin,
  output logic [7:0]          pp_data_out,
  output logic                pp_data_oe,
  output logic                pp_strobe_out,
  output logic                pp_strobe_oe,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                fifo_full,
  output logic                idle,
  output logic                overflow,
  output logic                timeout,
  input  logic                err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int CNT_W = 16;

  localparam logic [LVL_W-1:0] LEVEL_FULL  = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [TIMEOUT_LOG2-1:0] tcnt, tcnt_nx;
  logic                    strobe_nx;
  logic [7:0]              data_nx;
  logic                    pop, push, drop, timeout_set;
  logic                    busy_meta, busy_s;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr, rptr;
  logic [LVL_W-1:0]        level_nx;

  // BUSY is asynchronous to clk32, so it is double-registered before use.
  always_ff @(posedge clk32) begin
    if (por) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= busy_pin;
      busy_s    <= busy_meta;
    end
  end

  // A full FIFO still accepts a write when the same edge pops the head.
  assign push = wr && (!fifo_full || pop);
  assign drop = wr && fifo_full && !pop;

  always_comb begin
    level_nx = fifo_level;
    if (push && !pop)
      level_nx = fifo_level + LVL_W'(1);
    else if (pop && !push)
      level_nx = fifo_level - LVL_W'(1);
  end

  always_ff @(posedge clk32) begin
    if (por) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)
        rptr <= rptr + DEPTH_LOG2'(1);
      fifo_level <= level_nx;
      fifo_full  <= (level_nx == LEVEL_FULL);
    end
  end

  always_ff @(posedge clk32) begin
    if (push && !por)
      mem[wptr] <= wdata;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    tcnt_nx     = tcnt;
    strobe_nx   = pp_strobe_out;
    data_nx     = pp_data_out;
    pop         = 1'b0;
    timeout_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && (fifo_level != '0) && !busy_s) begin
          pop      = 1'b1;
          data_nx  = mem[rptr];
          cnt_nx   = SETUP_LOAD;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          strobe_nx = 1'b0;
          cnt_nx    = STROBE_LOAD;
          state_nx  = S_STROBE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          strobe_nx = 1'b1;
          cnt_nx    = HOLD_LOAD;
          state_nx  = S_HOLD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          tcnt_nx  = '0;
          state_nx = S_WAIT;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        // A printer stuck busy is abandoned; the byte is treated as sent.
        if (!busy_s) begin
          state_nx = S_IDLE;
        end else if (&tcnt) begin
          timeout_set = 1'b1;
          state_nx    = S_IDLE;
        end else begin
          tcnt_nx = tcnt + TIMEOUT_LOG2'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (por) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      pp_strobe_out <= 1'b1;
      pp_data_out   <= 8'h00;
      pp_data_oe    <= 1'b0;
      pp_strobe_oe  <= 1'b0;
      idle          <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      tcnt          <= tcnt_nx;
      pp_strobe_out <= strobe_nx;
      pp_data_out   <= data_nx;
      pp_data_oe    <= en;
      pp_strobe_oe  <= en;
      idle          <= (level_nx == '0) && (state_nx == S_IDLE);
    end
  end

  // Sticky error flags; a set event on the same edge beats err_clr.
  always_ff @(posedge clk32) begin
    if (por) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (timeout_set)
        timeout <= 1'b1;
      else if (err_clr)
        timeout <= 1'b0;
    end
  end

endmodule
